// File: rtl/approx_mac_acc.sv
// rtl/approx_mac_acc.sv - approx_9 multiply + LEN-term accumulate, valid/ready in and out.
// Define ACC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module approx_mac_acc #(
  parameter int ACC_W = 16,
  parameter int LEN   = 16,
  parameter int CNT_W = $clog2(LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  logic [7:0]       p_q, p_d;
  logic             p_vld_q, p_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;

  logic [7:0]       prod;
  logic             accept;
  logic             complete;
  logic [ACC_W:0]   add_w;

  // approx_9: each product column is OR-compressed; the MSB is tied high.
  always_comb begin
    prod = 8'h00;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        prod[i+j] = prod[i+j] | (in_a[i] & in_b[j]);
      end
    end
    prod[7] = 1'b1;
  end

  assign in_ready = ~clr & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign add_w    = {1'b0, acc_q} + {1'b0, ACC_W'(p_q)};

  always_comb begin
    p_d         = p_q;
    p_vld_d     = accept;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    complete    = 1'b0;

    if (accept) p_d = prod;

    // clr drops the in-flight product along with the partial sum.
    if (clr) begin
      cnt_d = '0;
    end else if (p_vld_q) begin
      if (cnt_q == '0) begin
        acc_d = ACC_W'(p_q);
        ovf_d = 1'b0;
      end else begin
        ovf_d = ovf_q | add_w[ACC_W];
`ifdef ACC_SAT_EN
        acc_d = (ovf_q | add_w[ACC_W]) ? {ACC_W{1'b1}} : add_w[ACC_W-1:0];
`else
        acc_d = add_w[ACC_W-1:0];
`endif
      end
      if (cnt_q == CNT_W'(LEN - 1)) begin
        complete = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (complete) begin
      out_valid_d = 1'b1;
      out_sum_d   = acc_d;
      out_ovf_d   = ovf_d;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q         <= '0;
      p_vld_q     <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      p_q         <= p_d;
      p_vld_q     <= p_vld_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

endmodule
